// File: rtl/hnf_biq_ctl_pkg.sv
// Shared definitions for the HN-F back-invalidation queue slice.
//   CACHE_BLOCK_OFFSET : byte-offset bits ignored by line-address compares (64 B lines)
//   biq_state_e        : sequencer state encoding (IDLE=0, ISSUE=1, WAIT=2, POP=3)
//   ptr_w()            : index width for an N-entry structure, never below 1 bit
package hnf_biq_ctl_pkg;

    localparam int CACHE_BLOCK_OFFSET = 6;

    typedef enum logic [1:0] {
        BIQ_IDLE  = 2'd0,
        BIQ_ISSUE = 2'd1,
        BIQ_WAIT  = 2'd2,
        BIQ_POP   = 2'd3
    } biq_state_e;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hnf_biq.sv
// Back-invalidation queue: circular FIFO of line addresses with a per-entry valid bit
// so every pending address can be matched against a lookup in parallel.
//   clk, rst        : clock, asynchronous active-high reset
//   push, data_in   : enqueue data_in at the tail
//   pop             : drop the head entry (push and pop may coincide, also when full)
//   addr_out        : head entry
//   full, empty     : occupancy flags
//   find, find_addr : line lookup; hit = find_addr's line matches any valid entry
module hnf_biq
    import hnf_biq_ctl_pkg::*;
#(
    parameter int BIQ_WIDTH = 44,
    parameter int BIQ_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [BIQ_WIDTH-1:0] data_in,
    input  logic                 pop,
    input  logic                 find,
    input  logic [BIQ_WIDTH-1:0] find_addr,
    output logic [BIQ_WIDTH-1:0] addr_out,
    output logic                 full,
    output logic                 empty,
    output logic                 hit
);

    localparam int PTR_W = ptr_w(BIQ_DEPTH);
    localparam logic [BIQ_WIDTH-1:0] LINE_MASK = {BIQ_WIDTH{1'b1}} << CACHE_BLOCK_OFFSET;

    logic [BIQ_WIDTH-1:0] mem [BIQ_DEPTH];
    logic [BIQ_DEPTH-1:0] vld;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BIQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: state is updated with <= so every flop samples pre-edge values; here that
    // also makes the push's vld set win over the pop's clear when both hit one slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            vld    <= '0;
        end else begin
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= next_ptr(rd_ptr);
            end
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= next_ptr(wr_ptr);
            end
        end
    end

    // NOTE: the data array has no reset; vld qualifies every read, so stale contents
    // are never observed and the array can map onto plain storage.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    assign addr_out = mem[rd_ptr];
    assign full     = &vld;
    assign empty    = ~|vld;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < BIQ_DEPTH; i++) begin
            if (vld[i] && (((mem[i] ^ find_addr) & LINE_MASK) == '0)) hit = 1'b1;
        end
        hit = hit & find;
    end

endmodule

// File: rtl/hnf_biq_ctl.sv
// HN-F back-invalidation sequencer and push arbiter.
//   clk, rst                  : clock, asynchronous active-high reset
//   src_valid/src_addr        : NUM_SRC eviction sources, address i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   src_ready                 : one-hot push accept (round-robin grant)
//   snp_req_valid/addr/ready  : one back-invalidation snoop at a time for the queue head
//   snp_done                  : pulse when all responses for the issued snoop are in
//   lkup_valid/addr, lkup_hit : pipeline stall lookup against every queued line
//   biq_full, busy, err_tmo   : status; err_tmo is sticky once a WAIT overruns WAIT_TMO
module hnf_biq_ctl
    import hnf_biq_ctl_pkg::*;
#(
    parameter int ADDR_WIDTH = 44,
    parameter int BIQ_DEPTH  = 4,
    parameter int NUM_SRC    = 2,
    parameter int WAIT_TMO   = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          snp_req_valid,
    output logic [ADDR_WIDTH-1:0]         snp_req_addr,
    input  logic                          snp_req_ready,
    input  logic                          snp_done,
    input  logic                          lkup_valid,
    input  logic [ADDR_WIDTH-1:0]         lkup_addr,
    output logic                          lkup_hit,
    output logic                          biq_full,
    output logic                          busy,
    output logic                          err_tmo
);

    localparam int SRC_W = ptr_w(NUM_SRC);
    localparam int CNT_W = $clog2(WAIT_TMO + 1);

    biq_state_e             state, state_nxt;
    logic [SRC_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]       wait_cnt;
    logic                   gnt_vld;
    logic [SRC_W-1:0]       gnt_idx;
    logic [ADDR_WIDTH-1:0]  push_addr;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic                   biq_push;
    logic                   biq_pop;
    logic                   biq_empty;

    // Round-robin grant: first valid source at or after rr_ptr, wrapping.
    // NOTE: every output of a combinational block gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin : arb
        logic [SRC_W:0] cand;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        push_addr = '0;
        src_ready = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
            if (cand >= (SRC_W + 1)'(NUM_SRC)) cand = cand - (SRC_W + 1)'(NUM_SRC);
            if (!gnt_vld && src_valid[cand[SRC_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[SRC_W-1:0];
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_idx == SRC_W'(i)) push_addr = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        // A full queue still accepts in the POP cycle: the freed slot is reused at once.
        if (gnt_vld && (!biq_full || biq_pop) && !rst) src_ready[gnt_idx] = 1'b1;
    end

    assign biq_push = |src_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (biq_push) begin
            rr_ptr <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BIQ_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        snp_req_valid = 1'b0;
        biq_pop       = 1'b0;
        case (state)
            BIQ_IDLE:  if (!biq_empty) state_nxt = BIQ_ISSUE;
            BIQ_ISSUE: begin
                snp_req_valid = 1'b1;
                if (snp_req_ready) state_nxt = BIQ_WAIT;
            end
            BIQ_WAIT:  if (snp_done) state_nxt = BIQ_POP;
            BIQ_POP:   begin
                biq_pop   = 1'b1;
                state_nxt = BIQ_IDLE;
            end
            default:   state_nxt = BIQ_IDLE;
        endcase
    end

    // The head stays queued until POP, so the in-flight line keeps blocking lookups.
    assign snp_req_addr = snp_req_valid ? head_addr : '0;
    assign busy         = !biq_empty || (state != BIQ_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_tmo  <= 1'b0;
        end else if (state == BIQ_WAIT) begin
            if (wait_cnt == CNT_W'(WAIT_TMO)) err_tmo  <= 1'b1;
            else                              wait_cnt <= wait_cnt + 1'b1;
        end else if (state == BIQ_POP) begin
            wait_cnt <= '0;
        end
    end

    hnf_biq #(
        .BIQ_WIDTH (ADDR_WIDTH),
        .BIQ_DEPTH (BIQ_DEPTH)
    ) u_biq (
        .clk       (clk),
        .rst       (rst),
        .push      (biq_push),
        .data_in   (push_addr),
        .pop       (biq_pop),
        .find      (lkup_valid),
        .find_addr (lkup_addr),
        .addr_out  (head_addr),
        .full      (biq_full),
        .empty     (biq_empty),
        .hit       (lkup_hit)
    );

    // A completion with no snoop outstanding has nothing to retire; it is dropped.
    snp_done_in_wait: assert property (@(posedge clk) disable iff (rst)
        snp_done |-> (state == BIQ_WAIT))
        else $warning("snp_done outside WAIT ignored");

endmodule
